mem_arb_intf: RTL and testbench
===============================

MEM_ARB_INTF -- requirements
Module: mem_arb_intf

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requester channels, legal 1..8.
REQ-002 SHALL have parameter DW, default 16: data width.
REQ-003 SHALL have parameter AW, default 14: address width.
REQ-004 SHALL have parameter TMO, default 16: max cycles waiting for mem_resp, legal 2..255.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port store  input  NCH  per-channel write request, held level until mem_done/mem_err for that channel.
REQ-008 SHALL have port load  input  NCH  per-channel read request, held level until mem_done/mem_err for that channel.
REQ-009 SHALL have port result  input  NCH*DW  per-channel write data; channel i at [i*DW +: DW].
REQ-010 SHALL have port addr  input  NCH*AW  per-channel address; channel i at [i*AW +: AW].
REQ-011 SHALL have port mem_done  output  NCH  one-cycle completion pulse, per channel.
REQ-012 SHALL have port mem_err  output  NCH  one-cycle timeout pulse, per channel.
REQ-013 SHALL have port rd_data  output  DW  read data, valid in the mem_done cycle of a load.
REQ-014 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-015 SHALL have port write_req  output  1  memory write strobe.
REQ-016 SHALL have port read_req  output  1  memory read strobe.
REQ-017 SHALL have port addrout  output  AW  memory address.
REQ-018 SHALL have port wdata  output  DW  memory write data.
REQ-019 SHALL have port rdata  input  DW  memory read data, valid when mem_resp=1.
REQ-020 SHALL have port mem_resp  input  1  memory acknowledge.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, DONE; all outputs registered.
REQ-022 Channel i SHALL be pending when store[i] | load[i]; if both are high, the request SHALL be treated as a store.
REQ-023 In IDLE with ≥1 pending channel, SHALL grant the first pending channel searching upward from rr_ptr with wrap at NCH-1→0, latch its op/addr/result, and go to REQ.
REQ-024 In REQ, SHALL drive exactly one of write_req/read_req = 1, with addrout/wdata from the latch, constant for the whole state.
REQ-025 In REQ, mem_resp=1 SHALL: capture rdata (loads only), go to DONE, and deassert both strobes from the next cycle.
REQ-026 In REQ, SHALL count cycles from 0; at count TMO-1 without mem_resp, SHALL go to DONE flagged as timeout; mem_resp in that same cycle wins (no timeout).
REQ-027 In DONE, SHALL pulse mem_done[gnt] (success) or mem_err[gnt] (timeout) for exactly 1 cycle, set rr_ptr = (gnt+1) mod NCH, and go to IDLE.
REQ-028 rd_data SHALL hold the last captured read value until the next load completes; on store completion and on timeout it SHALL be unchanged.
REQ-029 Latency SHALL be: grant cycle + N REQ cycles (N ≥ 1, including the mem_resp cycle) + 1 DONE cycle; minimum 3 cycles from request to done.
REQ-030 mem_resp SHALL be ignored in IDLE and DONE.
REQ-031 Requests arriving while busy SHALL wait; no request SHALL be dropped; changes to a granted channel's inputs after grant SHALL have no effect.
REQ-032 The requester SHALL deassert in the cycle after its done pulse; IDLE SHALL sample pending only after DONE, so no duplicate issue occurs.

Reset
REQ-033 reset_n=0 SHALL immediately force FSM=IDLE, rr_ptr=0, timeout count=0, and all outputs (mem_done, mem_err, rd_data, busy, write_req, read_req, addrout, wdata) = 0.
REQ-034 Reset asserted during REQ SHALL abort the access without any done/err pulse; after release, still-held requests SHALL be re-arbitrated from rr_ptr=0.

Verification
REQ-035 Single store: ch0 store, addr=0x0123, result=0xBEEF, mem_resp after 2 cycles -> write_req=1 for 2 cycles with addrout=0x0123, wdata=0xBEEF; mem_done[0] pulses 1 cycle; mem_err=0.
REQ-036 Single load: ch1 load, addr=0x3FFF, rdata=0xA55A with mem_resp -> read_req=1; rd_data=0xA55A in the mem_done[1] cycle and held afterward.
REQ-037 Contention: ch0 and ch1 both load continuously after reset -> grants alternate 0,1,0,1; each done pulses once per access; no two strobes high at once.
REQ-038 Timeout: TMO=16, ch0 store, mem_resp never asserted -> write_req high for 16 cycles, then mem_err[0] pulses, mem_done[0] stays 0, rd_data unchanged; a late mem_resp in IDLE is ignored.
REQ-039 Simultaneous store+load on ch1 -> write_req only; mem_resp at count TMO-1 -> mem_done[1], no mem_err.
REQ-040 Reset mid-REQ -> all outputs 0 within the reset cycle, no done/err pulse; a held request is re-issued after release.

Source files
------------

// File: rtl/mem_arb_intf.sv
// Round-robin arbiter that funnels NCH requester channels onto one memory
// port. Each granted access runs IDLE -> REQ -> DONE; REQ ends on mem_resp
// or after TMO cycles, and DONE emits a one-cycle done or error pulse back
// to the granted channel. Every output is driven directly from a register.
module mem_arb_intf #(
   parameter int NCH = 2,
   parameter int DW  = 16,
   parameter int AW  = 14,
   parameter int TMO = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NCH-1:0]    store,
   input  logic [NCH-1:0]    load,
   input  logic [NCH*DW-1:0] result,
   input  logic [NCH*AW-1:0] addr,
   output logic [NCH-1:0]    mem_done,
   output logic [NCH-1:0]    mem_err,
   output logic [DW-1:0]     rd_data,
   output logic              busy,
   output logic              write_req,
   output logic              read_req,
   output logic [AW-1:0]     addrout,
   output logic [DW-1:0]     wdata,
   input  logic [DW-1:0]     rdata,
   input  logic              mem_resp
);

   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = 8;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t         state_reg, state_next;
   logic [GW-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [GW-1:0]  gnt_reg, gnt_next;
   logic           is_store_reg, is_store_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [NCH-1:0] done_reg, done_next;
   logic [NCH-1:0] err_reg, err_next;
   logic [DW-1:0]  rd_data_reg, rd_data_next;
   logic           busy_reg, busy_next;
   logic           wr_reg, wr_next;
   logic           rd_reg, rd_next;
   logic [AW-1:0]  addr_reg, addr_next;
   logic [DW-1:0]  wdata_reg, wdata_next;

   // Per-channel views of the packed request buses.
   logic [NCH-1:0] pend;
   logic [AW-1:0]  ch_addr [NCH];
   logic [DW-1:0]  ch_data [NCH];

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign pend[gi]    = store[gi] | load[gi];
         assign ch_addr[gi] = addr[gi*AW +: AW];
         assign ch_data[gi] = result[gi*DW +: DW];
      end
   endgenerate

   // Round-robin pick: first pending channel at or above rr_ptr, wrapping.
   logic [GW-1:0] arb_gnt;
   logic          arb_found;
   logic [GW:0]   cand;
   always_comb begin
      arb_gnt   = '0;
      arb_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = {1'b0, rr_ptr_reg} + (GW+1)'(k);
         if (cand >= (GW+1)'(NCH))
            cand = cand - (GW+1)'(NCH);
         if (!arb_found && pend[cand[GW-1:0]]) begin
            arb_found = 1'b1;
            arb_gnt   = cand[GW-1:0];
         end
      end
   end

   // Next-state and next-output logic; pulses default low, the rest hold.
   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      gnt_next      = gnt_reg;
      is_store_next = is_store_reg;
      cnt_next      = cnt_reg;
      done_next     = '0;
      err_next      = '0;
      rd_data_next  = rd_data_reg;
      wr_next       = wr_reg;
      rd_next       = rd_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      case (state_reg)
         IDLE: begin
            if (arb_found) begin
               // A channel raising both store and load is served as a store.
               gnt_next      = arb_gnt;
               is_store_next = store[arb_gnt];
               addr_next     = ch_addr[arb_gnt];
               wdata_next    = ch_data[arb_gnt];
               wr_next       = store[arb_gnt];
               rd_next       = ~store[arb_gnt];
               cnt_next      = '0;
               state_next    = REQ;
            end
         end
         REQ: begin
            if (mem_resp) begin
               // A response on the final count still counts as success.
               if (!is_store_reg)
                  rd_data_next = rdata;
               done_next[gnt_reg] = 1'b1;
               wr_next            = 1'b0;
               rd_next            = 1'b0;
               cnt_next           = '0;
               state_next         = DONE;
            end else if (cnt_reg == CW'(TMO - 1)) begin
               err_next[gnt_reg] = 1'b1;
               wr_next           = 1'b0;
               rd_next           = 1'b0;
               cnt_next          = '0;
               state_next        = DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            rr_ptr_next = (gnt_reg == GW'(NCH - 1)) ? '0 : gnt_reg + 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // State and output registers; reset aborts any access without a pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         gnt_reg      <= '0;
         is_store_reg <= 1'b0;
         cnt_reg      <= '0;
         done_reg     <= '0;
         err_reg      <= '0;
         rd_data_reg  <= '0;
         busy_reg     <= 1'b0;
         wr_reg       <= 1'b0;
         rd_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         gnt_reg      <= gnt_next;
         is_store_reg <= is_store_next;
         cnt_reg      <= cnt_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         rd_data_reg  <= rd_data_next;
         busy_reg     <= busy_next;
         wr_reg       <= wr_next;
         rd_reg       <= rd_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
      end
   end

   assign mem_done  = done_reg;
   assign mem_err   = err_reg;
   assign rd_data   = rd_data_reg;
   assign busy      = busy_reg;
   assign write_req = wr_reg;
   assign read_req  = rd_reg;
   assign addrout   = addr_reg;
   assign wdata     = wdata_reg;

endmodule

// File: tb/tb_mem_arb_intf.sv
// Directed bench for mem_arb_intf with hand-computed expectations.
module tb_mem_arb_intf;

   localparam int NCH = 2;
   localparam int DW  = 16;
   localparam int AW  = 14;
   localparam int TMO = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NCH-1:0]    store, load;
   logic [NCH*DW-1:0] result;
   logic [NCH*AW-1:0] addr;
   logic [NCH-1:0]    mem_done, mem_err;
   logic [DW-1:0]     rd_data;
   logic              busy, write_req, read_req;
   logic [AW-1:0]     addrout;
   logic [DW-1:0]     wdata;
   logic [DW-1:0]     rdata;
   logic              mem_resp;

   int checks = 0;
   int errors = 0;

   // Results of the most recent single access.
   int          n_wr, n_rd, n_both, n_var, lat;
   logic [1:0]  done_v, err_v;
   logic [15:0] rdd, seen_wd;
   logic [13:0] seen_a;

   mem_arb_intf #(.NCH(NCH), .DW(DW), .AW(AW), .TMO(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .store(store), .load(load),
      .result(result), .addr(addr), .mem_done(mem_done), .mem_err(mem_err),
      .rd_data(rd_data), .busy(busy), .write_req(write_req),
      .read_req(read_req), .addrout(addrout), .wdata(wdata),
      .rdata(rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one request on channel ch and act as memory: mem_resp is raised
   // during the resp_at-th strobe cycle (0 = never). Called at a negedge.
   task automatic access(input bit ch, input logic st, input logic ld,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int resp_at, input logic [DW-1:0] rdv);
      bit fin;
      int n;
      if (ch) begin
         store[1] = st; load[1] = ld; addr[AW +: AW] = a; result[DW +: DW] = d;
      end else begin
         store[0] = st; load[0] = ld; addr[0 +: AW] = a; result[0 +: DW] = d;
      end
      rdata = rdv;
      n_wr = 0; n_rd = 0; n_both = 0; n_var = 0; lat = 0; n = 0;
      done_v = '0; err_v = '0; rdd = '0; seen_a = '0; seen_wd = '0;
      fin = 1'b0;
      for (int k = 1; k <= 40 && !fin; k++) begin
         @(negedge clk);
         if (write_req) n_wr++;
         if (read_req)  n_rd++;
         if (write_req && read_req) n_both++;
         if (write_req || read_req) begin
            n++;
            if (n == 1) begin
               seen_a = addrout; seen_wd = wdata;
            end else if (addrout !== seen_a || wdata !== seen_wd) begin
               n_var++;
            end
         end
         if (mem_done != '0 || mem_err != '0) begin
            done_v = mem_done; err_v = mem_err; rdd = rd_data; lat = k; fin = 1'b1;
            store = '0; load = '0; mem_resp = 1'b0;
         end else begin
            mem_resp = (resp_at > 0 && n == resp_at);
         end
      end
      if (!fin) begin
         chk("access_bound", 32'd0, 32'd1);
         store = '0; load = '0; mem_resp = 1'b0;
      end
      $display("txn ch%0d st=%0d ld=%0d addr=0x%0h wr=%0d rd=%0d lat=%0d done=%b err=%b rd_data=0x%0h",
               ch, st, ld, a, n_wr, n_rd, lat, done_v, err_v, rdd);
   endtask

   initial begin
      int ndone;
      logic [1:0] reass;
      logic [13:0] a_seen;
      logic [1:0] order [4];

      reset_n = 1'b0; store = '0; load = '0; result = '0; addr = '0;
      rdata = '0; mem_resp = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_done", mem_done, 0); chk("rst_err", mem_err, 0);
      chk("rst_rd_data", rd_data, 0); chk("rst_busy", busy, 0);
      chk("rst_wr", write_req, 0); chk("rst_rd", read_req, 0);
      chk("rst_addrout", addrout, 0); chk("rst_wdata", wdata, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single store, response in second REQ cycle
      access(1'b0, 1'b1, 1'b0, 14'h0123, 16'hBEEF, 2, 16'h0000);
      chk("st_wr_cycles", n_wr, 2); chk("st_rd_cycles", n_rd, 0);
      chk("st_addr", seen_a, 14'h0123); chk("st_wdata", seen_wd, 16'hBEEF);
      chk("st_stable", n_var, 0);
      chk("st_done", done_v, 2'b01); chk("st_err", err_v, 2'b00);
      chk("st_latency", lat, 3);
      @(negedge clk);
      chk("st_done_1cyc", mem_done, 0); chk("st_idle_busy", busy, 0);

      // Single load on ch1, minimum latency
      access(1'b1, 1'b0, 1'b1, 14'h3FFF, 16'h0000, 1, 16'hA55A);
      chk("ld_rd_cycles", n_rd, 1); chk("ld_wr_cycles", n_wr, 0);
      chk("ld_addr", seen_a, 14'h3FFF); chk("ld_done", done_v, 2'b10);
      chk("ld_err", err_v, 2'b00); chk("ld_rd_data", rdd, 16'hA55A);
      chk("ld_latency", lat, 2);
      rdata = 16'hFFFF;
      repeat (2) @(negedge clk);
      chk("ld_rd_data_held", rd_data, 16'hA55A);

      // Timeout: no response ever
      access(1'b0, 1'b1, 1'b0, 14'h0042, 16'h1234, 0, 16'h7777);
      chk("tmo_wr_cycles", n_wr, TMO); chk("tmo_err", err_v, 2'b01);
      chk("tmo_done", done_v, 2'b00); chk("tmo_rd_data", rdd, 16'hA55A);
      chk("tmo_latency", lat, TMO + 1);
      mem_resp = 1'b1;
      @(negedge clk);
      chk("late_resp_done", mem_done, 0); chk("late_resp_err", mem_err, 0);
      @(negedge clk);
      chk("late_resp_idle_done", mem_done, 0); chk("late_resp_busy", busy, 0);
      chk("late_resp_wr", write_req, 0);
      mem_resp = 1'b0;

      // Store+load on ch1 is a store; response on the last count wins
      access(1'b1, 1'b1, 1'b1, 14'h0777, 16'hC0DE, TMO, 16'h5555);
      chk("both_wr_cycles", n_wr, TMO); chk("both_rd_cycles", n_rd, 0);
      chk("both_done", done_v, 2'b10); chk("both_err", err_v, 2'b00);
      chk("both_rd_data", rdd, 16'hA55A); chk("both_wdata", seen_wd, 16'hC0DE);
      @(negedge clk);

      // Contention: both channels loading continuously
      addr = {14'h0555, 14'h0AAA};
      load = 2'b11;
      ndone = 0; reass = 2'b00; a_seen = '0;
      for (int k = 0; k < 60 && ndone < 4; k++) begin
         @(negedge clk);
         load = load | reass; reass = 2'b00;
         chk("cont_one_strobe", {31'd0, write_req & read_req}, 0);
         if (read_req) a_seen = addrout;
         if (mem_done != '0) begin
            chk("cont_rd_data", rd_data, 16'h1000 + 16'(ndone));
            chk("cont_err", mem_err, 0);
            order[ndone] = mem_done;
            chk("cont_addr", a_seen, mem_done[1] ? 14'h0555 : 14'h0AAA);
            $display("txn contention grant=%b rd_data=0x%0h", mem_done, rd_data);
            load = load & ~mem_done;
            reass = mem_done;
            ndone++;
            mem_resp = 1'b0;
            if (ndone == 4) load = 2'b00;
         end else begin
            mem_resp = read_req;
            rdata = 16'h1000 + 16'(ndone);
         end
      end
      chk("cont_count", ndone, 4);
      chk("cont_g0", order[0], 2'b01); chk("cont_g1", order[1], 2'b10);
      chk("cont_g2", order[2], 2'b01); chk("cont_g3", order[3], 2'b10);
      @(negedge clk);

      // Reset during REQ; re-arbitration restarts from channel 0
      access(1'b0, 1'b1, 1'b0, 14'h0100, 16'h1111, 1, 16'h0000);
      chk("pre_rst_done", done_v, 2'b01);
      @(negedge clk);
      store = 2'b11; addr = {14'h0200, 14'h0100}; result = {16'h2222, 16'h1111};
      @(negedge clk);
      chk("pre_rst_wr", write_req, 1); chk("pre_rst_addr", addrout, 14'h0200);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0); chk("mid_rst_wr", write_req, 0);
      chk("mid_rst_addr", addrout, 0); chk("mid_rst_wdata", wdata, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      chk("mid_rst_done", mem_done, 0); chk("mid_rst_err", mem_err, 0);
      @(negedge clk);
      chk("mid_rst_done2", mem_done, 0); chk("mid_rst_err2", mem_err, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reissue_wr", write_req, 1); chk("reissue_addr", addrout, 14'h0100);
      chk("reissue_wdata", wdata, 16'h1111); chk("reissue_done", mem_done, 0);
      mem_resp = 1'b1;
      @(negedge clk);
      chk("reissue_done0", mem_done, 2'b01);
      $display("txn reissue ch0 done=%b", mem_done);
      store[0] = 1'b0; mem_resp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("next_wr", write_req, 1); chk("next_addr", addrout, 14'h0200);
      mem_resp = 1'b1;
      @(negedge clk);
      chk("next_done1", mem_done, 2'b10);
      $display("txn follow-up ch1 done=%b", mem_done);
      store = '0; mem_resp = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
